ds_multichan_decimator: RTL and testbench
=========================================

# ds_multichan_decimator

Synthesisable multi-channel counting decimator for first-order delta-sigma modulator bitstreams, the RTL successor of the behavioural single-channel ds_adc model. It accumulates CHANNELS parallel 1-bit streams over OSR oversample strobes and converts each window to a signed sample using the same scaling as the model: analog = sample / (OSR/2). Completed frames are buffered and drained one channel at a time over a valid/ready stream. It sits between the modulator front end and downstream DSP.

## Interface
- CHANNELS, 4, number of parallel bitstreams (1..16)
- OSR, 256, oversampling ratio, even, ≥ 4
- WIDTH, 8, output sample width, signed two's complement
- clk  input  1  single clock; all logic on posedge
- rst  input  1  asynchronous, active-high reset
- bit_valid  input  1  oversample strobe; bit_in is sampled only when high
- bit_in  input  CHANNELS  modulator bits, one per channel
- out_valid  output  1  out_data/out_chan hold a sample
- out_ready  input  1  downstream accepts when high with out_valid
- out_data  output  WIDTH  signed decimated sample
- out_chan  output  $clog2(CHANNELS) (min 1)  channel index of out_data
- out_last  output  1  high with the final channel of a frame
- overrun  output  1  sticky: a frame was dropped
- overrun_clr  input  1  clears overrun

## Operation
- Window counter counts bit_valid strobes 0..OSR-1, then wraps to 0; bit_valid low freezes all accumulation.
- Per channel ones counter, width $clog2(OSR+1), adds bit_in[c] on each strobe; cleared at window start.
- On the OSR-th strobe (counter = OSR-1), sample[c] = ones[c] (including this strobe's bit) − OSR/2, range −OSR/2..+OSR/2, computed at $clog2(OSR+1)+1 bits and then reduced to WIDTH (see Configuration).
- Frame buffer: one CHANNELS×WIDTH register set, written at window end only if the buffer is free; otherwise the frame is discarded and overrun is set.
- Drain FSM: IDLE (buffer free, out_valid=0) → DRAIN when a frame is loaded; in DRAIN, out_chan starts at 0 and advances on each out_valid&&out_ready; handshake with out_last=1 (chan CHANNELS−1) returns to IDLE.
- Simultaneous last-channel handshake and window end: the buffer counts as free, new frame loads, FSM stays in DRAIN with out_chan=0 next cycle, no overrun.
- out_data/out_chan stable while out_valid && !out_ready.
- overrun: set on drop, cleared by overrun_clr; if both occur the same cycle, set wins.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, out_last=0, overrun=0, window counter=0, ones counters=0, FSM=IDLE.
- Latency: out_valid rises the cycle after the clock edge that samples the OSR-th strobe.
- Throughput: one sample per cycle while out_ready=1; a frame drains in CHANNELS cycles minimum.
- out_valid never drops without a handshake except on rst.
- rst mid-window discards partial accumulation; rst mid-drain discards the buffered frame; the first window after reset starts at the first bit_valid after rst deasserts.

## Configuration
- DS_DEC_SAT_EN defined: reduction to WIDTH saturates to [−2^(WIDTH−1), 2^(WIDTH−1)−1]; e.g. OSR=256, WIDTH=8: +128 → +127.
- DS_DEC_SAT_EN undefined: reduction truncates to the low WIDTH bits (two's-complement wrap); +128 → −128. Other values are identical in both builds when in range.

## Test plan
- Reset, then all channels held at a 50% duty pattern (1,0,1,0…) for one window, OSR=256 → four samples of 0, out_chan 0..3, out_last on chan 3, out_valid rises the cycle after strobe 256.
- Ch0 all ones, ch1 all zeros, ch2 1 in 4, ch3 3 in 4 → +127 (SAT) / −128 (no SAT), −128, −64, +64.
- bit_valid strobe every 3rd cycle, ch0 = 192 ones per window → sample +64; frozen cycles contribute nothing.
- out_ready held low across two window ends → first frame held stable, second frame dropped, overrun=1; overrun_clr pulse → 0; set/clear in the same cycle → stays 1.
- Last-channel handshake coincident with window end → next frame starts at chan 0 next cycle, overrun stays 0.
- rst asserted at strobe 100 of a window and again mid-drain → all outputs at reset values, and the first frame after reset reflects only post-reset bits.

Source files
------------

// File: rtl/ds_multichan_decimator.sv
// ds_multichan_decimator: counting decimator for CHANNELS parallel first-order
// delta-sigma bitstreams. Each OSR-strobe window becomes one signed sample per
// channel (ones - OSR/2), which is buffered and drained over valid/ready.
// Optional feature macro: DS_DEC_SAT_EN (saturate instead of wrap to WIDTH).
module ds_multichan_decimator #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned OSR      = 256,
    parameter int unsigned WIDTH    = 8
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               bit_valid,
    input  logic [CHANNELS-1:0]                                bit_in,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic [WIDTH-1:0]                                   out_data,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_chan,
    output logic                                               out_last,
    output logic                                               overrun,
    input  logic                                               overrun_clr
);

    localparam int unsigned CNT_W  = $clog2(OSR + 1);
    localparam int unsigned WIN_W  = $clog2(OSR);
    localparam int unsigned SUM_W  = CNT_W + 1;
    localparam int unsigned CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(OSR - 1);
    localparam logic [SUM_W-1:0]  HALF      = SUM_W'(OSR / 2);
    localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(CHANNELS - 1);

`ifdef DS_DEC_SAT_EN
    localparam int unsigned EXT_W = (SUM_W > WIDTH) ? SUM_W : WIDTH;
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(2 ** (WIDTH - 1)));
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Reduce a full-precision sample to the output width.
    function automatic logic [WIDTH-1:0] reduce(input logic signed [SUM_W-1:0] s);
`ifdef DS_DEC_SAT_EN
        logic signed [EXT_W-1:0] e;
        e = EXT_W'(s);
        if (e > SAT_MAX) begin
            return WIDTH'(SAT_MAX);
        end else if (e < SAT_MIN) begin
            return WIDTH'(SAT_MIN);
        end
        return WIDTH'(e);
`else
        return WIDTH'(s);
`endif
    endfunction

    logic [WIN_W-1:0]  win_q, win_d;
    logic [CNT_W-1:0]  ones_q [CHANNELS];
    logic [CNT_W-1:0]  ones_d [CHANNELS];
    logic [WIDTH-1:0]  buf_q  [CHANNELS];
    logic [WIDTH-1:0]  buf_d  [CHANNELS];
    logic [WIDTH-1:0]  samp   [CHANNELS];
    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [CHAN_W-1:0] out_chan_q, out_chan_d;
    logic              out_last_q, out_last_d;
    logic              overrun_q, overrun_d;

    logic              win_end;
    logic              hs;
    logic              buf_free;
    logic              load;
    logic [CNT_W-1:0]  full;

    // Window counting and per-channel ones accumulation; samples formed at window end.
    always_comb begin
        win_d   = win_q;
        win_end = bit_valid && (win_q == WIN_LAST);
        full    = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            ones_d[c] = ones_q[c];
            samp[c]   = '0;
        end
        if (bit_valid) begin
            win_d = win_end ? '0 : win_q + WIN_W'(1);
        end
        for (int c = 0; c < int'(CHANNELS); c++) begin
            full = ((win_q == '0) ? '0 : ones_q[c]) + CNT_W'(bit_in[c]);
            if (bit_valid) begin
                ones_d[c] = full;
            end
            samp[c] = reduce($signed(SUM_W'(full) - HALF));
        end
    end

    // Frame buffer load/drop, drain FSM and registered output stage.
    always_comb begin
        state_d   = state_q;
        out_chan_d = out_chan_q;
        overrun_d = overrun_q;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            buf_d[c] = buf_q[c];
        end

        hs       = out_valid_q && out_ready;
        buf_free = (state_q == IDLE) || (hs && out_last_q);
        load     = win_end && buf_free;

        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d    = DRAIN;
                    out_chan_d = '0;
                end
            end
            DRAIN: begin
                if (hs) begin
                    if (out_last_q) begin
                        out_chan_d = '0;
                        state_d    = load ? DRAIN : IDLE;
                    end else begin
                        out_chan_d = out_chan_q + CHAN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                buf_d[c] = samp[c];
            end
        end

        // Drop wins over clear when both happen together.
        if (win_end && !buf_free) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        out_valid_d = (state_d == DRAIN);
        out_data_d  = out_valid_d ? buf_d[out_chan_d] : out_data_q;
        out_last_d  = out_valid_d && (out_chan_d == CHAN_LAST);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q       <= '0;
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_last_q  <= 1'b0;
            overrun_q   <= 1'b0;
            for (int c = 0; c < int'(CHANNELS); c++) begin
                ones_q[c] <= '0;
                buf_q[c]  <= '0;
            end
        end else begin
            win_q       <= win_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_last_q  <= out_last_d;
            overrun_q   <= overrun_d;
            for (int c = 0; c < int'(CHANNELS); c++) begin
                ones_q[c] <= ones_d[c];
                buf_q[c]  <= buf_d[c];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_last  = out_last_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_ds_multichan_decimator.sv
// Self-checking bench for ds_multichan_decimator (CHANNELS=4, OSR=256, WIDTH=8).
// Each channel's bits repeat a 4-bit pattern, so a window holds 64*popcount ones
// and the expected sample is 64*popcount - 128.
module tb_ds_multichan_decimator;

    localparam int OSR = 256;

`ifdef DS_DEC_SAT_EN
    localparam int FULL_SCALE = 127;
`else
    localparam int FULL_SCALE = -128;
`endif

    typedef struct {
        logic [3:0][3:0] pats;
        logic [3:0][7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_valid;
    logic [3:0] bit_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_chan;
    logic       out_last;
    logic       overrun;
    logic       overrun_clr;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t vecs [4];
    vec_t vgap;

    ds_multichan_decimator #(.CHANNELS(4), .OSR(OSR), .WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .out_last   (out_last),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " out_valid"}, int'(out_valid), 0);
        chk({tag, " out_data"},  int'(out_data), 0);
        chk({tag, " out_chan"},  int'(out_chan), 0);
        chk({tag, " out_last"},  int'(out_last), 0);
        chk({tag, " overrun"},   int'(overrun), 0);
    endtask

    // One full window of OSR strobes, with 'gap' frozen cycles before each strobe.
    task automatic run_window(input logic [3:0][3:0] pats, input int gap,
                              input bit chk_lat, input bit clr_last,
                              input int rdy_early, input bit rdy_last);
        for (int i = 0; i < OSR; i++) begin
            for (int g = 0; g < gap; g++) begin
                bit_valid   = 1'b0;
                bit_in      = 4'hF;
                out_ready   = 1'b0;
                overrun_clr = 1'b0;
                tick();
            end
            bit_valid = 1'b1;
            for (int c = 0; c < 4; c++) begin
                int k;
                k = 3 - (i % 4);
                bit_in[c] = pats[c][k];
            end
            out_ready   = (i < rdy_early) || (rdy_last && i == OSR - 1);
            overrun_clr = clr_last && (i == OSR - 1);
            if (rdy_last && i == OSR - 1) begin
                chk("pre-coincide out_last", int'(out_last), 1);
                chk("pre-coincide out_chan", int'(out_chan), 3);
            end
            tick();
            if (chk_lat && i == OSR - 2) chk("latency before last strobe", int'(out_valid), 0);
            if (chk_lat && i == OSR - 1) chk("latency after last strobe", int'(out_valid), 1);
        end
        bit_valid   = 1'b0;
        bit_in      = 4'h0;
        out_ready   = 1'b0;
        overrun_clr = 1'b0;
    endtask

    // Drain channels first..last with out_ready held high.
    task automatic drain(input logic [3:0][7:0] exp, input int first, input int last);
        for (int c = first; c <= last; c++) begin
            out_ready = 1'b1;
            chk($sformatf("drain ch%0d out_valid", c), int'(out_valid), 1);
            chk($sformatf("drain ch%0d out_chan", c), int'(out_chan), c);
            chk($sformatf("drain ch%0d out_data", c), int'($signed(out_data)), int'($signed(exp[c])));
            chk($sformatf("drain ch%0d out_last", c), int'(out_last), (c == 3) ? 1 : 0);
            tick();
        end
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0].pats = {4'b1010, 4'b1010, 4'b1010, 4'b1010};
        vecs[0].exp  = {8'sd0, 8'sd0, 8'sd0, 8'sd0};
        vecs[1].pats = {4'b1110, 4'b1000, 4'b0000, 4'b1111};
        vecs[1].exp[0] = 8'(FULL_SCALE);
        vecs[1].exp[1] = 8'(-128);
        vecs[1].exp[2] = 8'(-64);
        vecs[1].exp[3] = 8'(64);
        vecs[2].pats = {4'b0110, 4'b1101, 4'b0100, 4'b1100};
        vecs[2].exp[0] = 8'(0);
        vecs[2].exp[1] = 8'(-64);
        vecs[2].exp[2] = 8'(64);
        vecs[2].exp[3] = 8'(0);
        vecs[3].pats = {4'b0011, 4'b0001, 4'b1011, 4'b0111};
        vecs[3].exp[0] = 8'(64);
        vecs[3].exp[1] = 8'(64);
        vecs[3].exp[2] = 8'(-64);
        vecs[3].exp[3] = 8'(0);
        vgap.pats = {4'b0000, 4'b0000, 4'b0000, 4'b1110};
        vgap.exp[0] = 8'(64);
        vgap.exp[1] = 8'(-128);
        vgap.exp[2] = 8'(-128);
        vgap.exp[3] = 8'(-128);

        rst = 1'b1; bit_valid = 1'b0; bit_in = 4'h0; out_ready = 1'b0; overrun_clr = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Table-driven windows: latency, per-channel values, ordering and out_last.
        for (int v = 0; v < 4; v++) begin
            run_window(vecs[v].pats, 0, 1'b1, 1'b0, 0, 1'b0);
            drain(vecs[v].exp, 0, 3);
            chk($sformatf("vec%0d idle after drain", v), int'(out_valid), 0);
        end

        // Sparse strobes with garbage bits on frozen cycles.
        run_window(vgap.pats, 2, 1'b1, 1'b0, 0, 1'b0);
        drain(vgap.exp, 0, 3);

        // Held frame across a second window end: second frame dropped.
        run_window(vecs[3].pats, 0, 1'b1, 1'b0, 0, 1'b0);
        tick();
        chk("stall out_data stable", int'($signed(out_data)), 64);
        run_window(vecs[2].pats, 0, 1'b0, 1'b0, 0, 1'b0);
        chk("drop sets overrun", int'(overrun), 1);
        chk("stall out_chan held", int'(out_chan), 0);
        chk("stall out_valid held", int'(out_valid), 1);
        drain(vecs[3].exp, 0, 3);
        chk("idle after held drain", int'(out_valid), 0);
        chk("overrun sticky", int'(overrun), 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("overrun_clr clears", int'(overrun), 0);

        // Drop and clear on the same edge: set wins.
        run_window(vecs[0].pats, 0, 1'b1, 1'b0, 0, 1'b0);
        run_window(vecs[1].pats, 0, 1'b0, 1'b1, 0, 1'b0);
        chk("set beats clear", int'(overrun), 1);
        drain(vecs[0].exp, 0, 3);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("overrun cleared again", int'(overrun), 0);

        // Last-channel handshake coincident with window end.
        run_window(vecs[2].pats, 0, 1'b1, 1'b0, 0, 1'b0);
        run_window(vecs[3].pats, 0, 1'b0, 1'b0, 3, 1'b1);
        chk("coincide overrun", int'(overrun), 0);
        drain(vecs[3].exp, 0, 3);
        chk("coincide idle after drain", int'(out_valid), 0);

        // Reset at strobe 100 of a window: partial accumulation discarded.
        for (int i = 0; i < 100; i++) begin
            bit_valid = 1'b1;
            bit_in    = 4'hF;
            tick();
        end
        bit_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk_reset_outputs("mid-window reset");
        rst = 1'b0;
        tick();
        tick();
        run_window(vecs[2].pats, 0, 1'b1, 1'b0, 0, 1'b0);
        drain(vecs[2].exp, 0, 3);

        // Reset mid-drain with overrun set: frame and flag discarded.
        run_window(vecs[3].pats, 0, 1'b1, 1'b0, 0, 1'b0);
        run_window(vecs[1].pats, 0, 1'b0, 1'b0, 0, 1'b0);
        chk("pre-reset overrun", int'(overrun), 1);
        drain(vecs[3].exp, 0, 1);
        rst = 1'b1;
        tick();
        chk_reset_outputs("mid-drain reset");
        rst = 1'b0;
        tick();
        chk("post-reset stays idle", int'(out_valid), 0);
        run_window(vecs[1].pats, 0, 1'b1, 1'b0, 0, 1'b0);
        drain(vecs[1].exp, 0, 3);
        chk("final idle", int'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
